led_scan_ctrl: RTL

Time-multiplexed scan controller for a 4-digit common-anode 7-segment display. It accepts a 16-bit hex value and 4 decimal-point flags over a ready/load handshake, and holds them in a shadow register. It sequences one shared hex-to-segment decoder across the digits with inter-digit blanking to suppress ghosting, and commits new values only at frame boundaries so the display never tears. It sits between the board-level user logic and the display pins.

---
 rtl/led_scan_pkg.sv | 25 ++
 rtl/hex_seg_decode.sv | 14 +
 rtl/led_scan_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared definitions for the LED scan controller.
//   scan_state_t   - FSM state encoding (IDLE / SHOW / BLANK)
//   SEG_PAT        - 16-entry active-low hex segment patterns {g,f,e,d,c,b,a}
//   SEG_BLANK_DIG  - pattern for a blanked (leading-zero) digit
//   SEG_OFF/AN_OFF - all segments / all anodes dark
package led_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_OFF       = 8'hFF;
    localparam logic [3:0] AN_OFF        = 4'hF;
    localparam logic [6:0] SEG_BLANK_DIG = 7'h7F;

    localparam logic [6:0] SEG_PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational hex nibble to 7-segment pattern.
// Ports:
//   nibble  in  4  hex digit value
//   seg_n   out 7  active-low segments {g,f,e,d,c,b,a}
module hex_seg_decode
    import led_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_PAT[nibble];

endmodule

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: 4-digit common-anode 7-segment scan controller.
// A value/dp pair is taken over a ready/load handshake into a pending
// register and committed to the display register only at a frame boundary
// (or immediately while idle), so a frame never mixes old and new digits.
//
// Parameters:
//   CLK_DIV       clock cycles per digit slot (> BLANK_CYCLES)
//   BLANK_CYCLES  dark cycles at the end of every slot (>= 1)
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   async active-low reset
//   enable      in   1 = scan, 0 = dark
//   load        in   load strobe, accepted while ready = 1
//   value       in   16  four hex nibbles, nibble k -> digit k
//   dp_in       in   4   decimal points, bit k -> digit k
//   ready       out  no commit pending
//   seg_n       out  8   active-low {dp,g,f,e,d,c,b,a}
//   an_n        out  4   active-low anodes
//   frame_tick  out  pulse on the last blank cycle of digit 3
//
// Build option: define LED_SCAN_LEADING_ZERO_BLANK_EN to blank leading
// zero digits 3..1 (anode and DP still driven).
//
// state  | meaning
// -------+---------------------------------------------------
// IDLE   | display dark, waiting for enable
// SHOW   | anode of digit d on, decoded nibble on segments
// BLANK  | all dark between digits to suppress ghosting
module led_scan_ctrl
    import led_scan_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic        ready,
    output logic [7:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(CLK_DIV - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;

    logic [15:0] disp_val_q, disp_val_d, pend_val_q;
    logic [3:0]  disp_dp_q, disp_dp_d, pend_dp_q;
    logic        ready_q, ready_d;

    logic        boundary, commit, load_acc;
    logic [3:0]  nibble_d;
    logic        dp_bit_d;
    logic        lead_zero;
    logic [6:0]  dec_seg;
    logic [7:0]  seg_d;
    logic [3:0]  an_d;
    logic        tick_d;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            dig_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    dig_d   = '0;
                end
                ST_SHOW: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == SHOW_LAST) state_d = ST_BLANK;
                end
                ST_BLANK: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        dig_d   = dig_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    dig_d   = '0;
                end
            endcase
        end
    end

    // ---------------- handshake / commit ----------------
    assign boundary = (state_q == ST_BLANK) && (cnt_q == CNT_LAST) && (dig_q == 2'd3);
    // ready_q = 1 implies nothing pending, so accept and commit never coincide;
    // a load taken on the boundary cycle therefore waits for the next boundary.
    assign commit   = !ready_q && ((state_q == ST_IDLE) || boundary);
    assign load_acc = load && ready_q;

    always_comb begin
        disp_val_d = commit ? pend_val_q : disp_val_q;
        disp_dp_d  = commit ? pend_dp_q  : disp_dp_q;
        ready_d    = ready_q;
        if (load_acc)    ready_d = 1'b0;
        else if (commit) ready_d = 1'b1;
    end

    // ---------------- next-cycle outputs ----------------
    // Outputs are computed from next-state values and registered, so they
    // line up with the state they describe and the new display value is
    // visible on the very first SHOW after a commit.
    always_comb begin
        unique case (dig_d)
            2'd0: begin nibble_d = disp_val_d[3:0];   dp_bit_d = disp_dp_d[0]; end
            2'd1: begin nibble_d = disp_val_d[7:4];   dp_bit_d = disp_dp_d[1]; end
            2'd2: begin nibble_d = disp_val_d[11:8];  dp_bit_d = disp_dp_d[2]; end
            2'd3: begin nibble_d = disp_val_d[15:12]; dp_bit_d = disp_dp_d[3]; end
            default: begin nibble_d = disp_val_d[3:0]; dp_bit_d = disp_dp_d[0]; end
        endcase
    end

    hex_seg_decode u_dec (
        .nibble (nibble_d),
        .seg_n  (dec_seg)
    );

    always_comb begin
`ifdef LED_SCAN_LEADING_ZERO_BLANK_EN
        unique case (dig_d)
            2'd3:    lead_zero = (disp_val_d[15:12] == 4'h0);
            2'd2:    lead_zero = (disp_val_d[15:8]  == 8'h00);
            2'd1:    lead_zero = (disp_val_d[15:4]  == 12'h000);
            default: lead_zero = 1'b0;
        endcase
`else
        lead_zero = 1'b0;
`endif
        seg_d  = SEG_OFF;
        an_d   = AN_OFF;
        if (state_d == ST_SHOW) begin
            seg_d = {~dp_bit_d, (lead_zero ? SEG_BLANK_DIG : dec_seg)};
            an_d  = ~(4'b0001 << dig_d);
        end
        tick_d = (state_d == ST_BLANK) && (cnt_d == CNT_LAST) && (dig_d == 2'd3);
    end

    // ---------------- data + output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            ready_q    <= 1'b1;
            seg_n      <= SEG_OFF;
            an_n       <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            if (load_acc) begin
                pend_val_q <= value;
                pend_dp_q  <= dp_in;
            end
            ready_q    <= ready_d;
            seg_n      <= seg_d;
            an_n       <= an_d;
            frame_tick <= tick_d;
        end
    end

    assign ready = ready_q;

endmodule
